// File: rtl/apb_pkg.sv
// Shared definitions for the APB requester family.
//   apb_state_e   : command master FSM states
//   APB_*_WIDTH   : default bus widths
//   cnt_width()   : bit width for a counter that must hold 0..max_count
package apb_pkg;

  localparam int unsigned APB_ADDR_WIDTH = 8;
  localparam int unsigned APB_DATA_WIDTH = 32;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ACCESS,
    CAPTURE,
    RESP
  } apb_state_e;

  // clog2(max_count+1), never below one bit so a disabled counter still elaborates.
  function automatic int unsigned cnt_width(input int unsigned max_count);
    int unsigned w;
    w = $clog2(max_count + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/apb_cmd_master_if.sv
// Command/response handshake plus APB4 bus signals of apb_cmd_master.
//   master modport : the requester's view (drives cmd_ready, rsp_*, P* outputs)
//   slave modport  : the surrounding environment's view (command source,
//                    response sink and the APB completer)
interface apb_cmd_master_if
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = APB_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = APB_DATA_WIDTH
) ();

  // command port
  logic                      cmd_valid;
  logic                      cmd_ready;
  logic                      cmd_write;
  logic [ADDR_WIDTH-1:0]     cmd_addr;
  logic [DATA_WIDTH-1:0]     cmd_wdata;
  logic [DATA_WIDTH/8-1:0]   cmd_strb;

  // response port
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [DATA_WIDTH-1:0]     rsp_rdata;
  logic                      rsp_err;
  logic                      rsp_timeout;

  // APB4
  logic [ADDR_WIDTH-1:0]     PADDR;
  logic                      PSEL;
  logic                      PENABLE;
  logic                      PWRITE;
  logic [DATA_WIDTH-1:0]     PWDATA;
  logic [DATA_WIDTH/8-1:0]   PSTRB;
  logic [DATA_WIDTH-1:0]     PRDATA;
  logic                      PREADY;
  logic                      PSLVERR;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  rsp_ready,
    output PADDR, PSEL, PENABLE, PWRITE, PWDATA, PSTRB,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output rsp_ready,
    input  PADDR, PSEL, PENABLE, PWRITE, PWDATA, PSTRB,
    output PRDATA, PREADY, PSLVERR
  );

endinterface

// File: rtl/apb_wait_timer.sv
// Saturating wait-state counter with synchronous clear.
//   PCLK, PRESET : clock, asynchronous active-high reset
//   clr          : restart counting from zero
//   en           : count one wait cycle
//   expired      : the current cycle is wait cycle number LIMIT (count == LIMIT-1);
//                  stuck low when LIMIT == 0
module apb_wait_timer
  import apb_pkg::*;
#(
  parameter int unsigned LIMIT = 16
) (
  input  logic PCLK,
  input  logic PRESET,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CW = cnt_width(LIMIT);

  logic [CW-1:0] cnt;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = (LIMIT != 0) && (cnt == CW'(LIMIT - 1));

endmodule

// File: rtl/apb_cmd_master.sv
// APB4 requester: takes one read/write command at a time, runs SETUP/ACCESS,
// and returns read data / error status on a valid-ready response port.
//   PCLK, PRESET : clock, asynchronous active-high reset
//   bus          : command port, response port and APB4 signals (master modport)
// Parameters:
//   TIMEOUT_CYCLES : ACCESS cycles with PREADY low before abort (0 = never)
//   RD_SAMPLE_DLY  : 1 = PRDATA is taken one cycle after the completing edge
module apb_cmd_master
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = APB_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH     = APB_DATA_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned RD_SAMPLE_DLY  = 1
) (
  input  logic               PCLK,
  input  logic               PRESET,
  apb_cmd_master_if.master   bus
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  apb_state_e state, state_nxt;

  logic take_cmd;
  logic xfer_done;
  logic xfer_abort;
  logic wait_expired;

  logic ready;
  logic sel;
  logic enable;
  logic valid;

  logic [ADDR_WIDTH-1:0] paddr_q;
  logic                  pwrite_q;
  logic [DATA_WIDTH-1:0] pwdata_q;
  logic [STRB_WIDTH-1:0] pstrb_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;
  logic                  timeout_q;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    take_cmd   = 1'b0;
    xfer_done  = 1'b0;
    xfer_abort = 1'b0;
    ready      = 1'b0;
    sel        = 1'b0;
    enable     = 1'b0;
    valid      = 1'b0;
    unique case (state)
      IDLE: begin
        ready = 1'b1;
        if (bus.cmd_valid) begin
          take_cmd  = 1'b1;
          state_nxt = SETUP;
        end
      end
      SETUP: begin
        sel       = 1'b1;
        state_nxt = ACCESS;
      end
      ACCESS: begin
        sel    = 1'b1;
        enable = 1'b1;
        // PREADY is checked first so a completion on the expiry cycle is not aborted.
        if (bus.PREADY) begin
          xfer_done = 1'b1;
          state_nxt = (!pwrite_q && (RD_SAMPLE_DLY != 0)) ? CAPTURE : RESP;
        end else if (wait_expired) begin
          xfer_abort = 1'b1;
          state_nxt  = RESP;
        end
      end
      CAPTURE: begin
        state_nxt = RESP;
      end
      RESP: begin
        valid = 1'b1;
        if (bus.rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      paddr_q   <= '0;
      pwrite_q  <= 1'b0;
      pwdata_q  <= '0;
      pstrb_q   <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      if (take_cmd) begin
        paddr_q   <= bus.cmd_addr;
        pwrite_q  <= bus.cmd_write;
        pwdata_q  <= bus.cmd_wdata;
        pstrb_q   <= bus.cmd_write ? bus.cmd_strb : '0;
        rdata_q   <= '0;
        err_q     <= 1'b0;
        timeout_q <= 1'b0;
      end
      if (xfer_done) begin
        err_q     <= bus.PSLVERR;
        timeout_q <= 1'b0;
        rdata_q   <= (!pwrite_q && (RD_SAMPLE_DLY == 0)) ? bus.PRDATA : '0;
      end
      if (xfer_abort) begin
        err_q     <= 1'b1;
        timeout_q <= 1'b1;
        rdata_q   <= '0;
      end
      if (state == CAPTURE) begin
        rdata_q <= bus.PRDATA;
      end
    end
  end

  apb_wait_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_wait_timer (
    .PCLK    (PCLK),
    .PRESET  (PRESET),
    .clr     (state == SETUP),
    .en      ((state == ACCESS) && !bus.PREADY),
    .expired (wait_expired)
  );

  assign bus.cmd_ready   = ready;
  assign bus.rsp_valid   = valid;
  assign bus.rsp_rdata   = rdata_q;
  assign bus.rsp_err     = err_q;
  assign bus.rsp_timeout = timeout_q;
  assign bus.PADDR       = paddr_q;
  assign bus.PSEL        = sel;
  assign bus.PENABLE     = enable;
  assign bus.PWRITE      = pwrite_q;
  assign bus.PWDATA      = pwdata_q;
  assign bus.PSTRB       = pstrb_q;

endmodule

// File: tb/tb_apb_cmd_master.sv
`timescale 1ns/1ps
module tb_apb_cmd_master;
  import apb_pkg::*;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = DW / 8;
  localparam int unsigned TO = 16;

  logic PCLK   = 1'b0;
  logic PRESET = 1'b1;
  always #5 PCLK = ~PCLK;

  apb_cmd_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  apb_cmd_master #(
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (TO),
    .RD_SAMPLE_DLY  (1)
  ) dut (
    .PCLK   (PCLK),
    .PRESET (PRESET),
    .bus    (bus)
  );

  int vec  = 0;
  int miss = 0;

  // ---------------- APB completer stub (registered PRDATA) ----------------
  logic [DW-1:0] slv_mem [256] = '{default: '0};
  int unsigned   slv_wait = 0;
  bit            slv_err  = 1'b0;
  int unsigned   acc_cnt  = 0;

  always @(posedge PCLK) begin
    if (bus.PSEL && bus.PENABLE && !bus.PREADY) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;
    if (bus.PSEL && bus.PENABLE && bus.PREADY) begin
      if (bus.PWRITE) begin
        if (!slv_err)
          for (int b = 0; b < SW; b++)
            if (bus.PSTRB[b]) slv_mem[bus.PADDR][8*b +: 8] <= bus.PWDATA[8*b +: 8];
      end else begin
        bus.PRDATA <= slv_mem[bus.PADDR];
      end
    end
  end

  assign bus.PREADY  = bus.PSEL && bus.PENABLE && (acc_cnt >= slv_wait);
  assign bus.PSLVERR = bus.PREADY && slv_err;

  // ---------------- reference model ----------------
  logic [DW-1:0] ref_mem [256] = '{default: '0};

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_v, input logic [DW-1:0] new_v,
                                          input logic [SW-1:0] st);
    logic [DW-1:0] m;
    m = '0;
    for (int b = 0; b < SW; b++) if (st[b]) m = m | (DW'(32'hFF) << (8 * b));
    return (old_v & ~m) | (new_v & m);
  endfunction

  typedef struct {
    logic [DW-1:0] rd;
    logic          err;
    logic          to;
    int            lat;
    int            n_setup;
    int            n_access;
    bit            bus_bad;
    bit            hold_bad;
    bit            post_bad;
    bit            hung;
  } res_t;

  // Drives one command, watches the APB phases, holds rsp_ready low for
  // 'hold' cycles once the response shows up, then completes the handshake.
  task automatic run_cmd(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                         input logic [SW-1:0] st, input int hold, output res_t r);
    int cyc;
    logic [SW-1:0] exp_strb;
    r = '{rd: '0, err: 1'b0, to: 1'b0, lat: 0, n_setup: 0, n_access: 0,
          bus_bad: 1'b0, hold_bad: 1'b0, post_bad: 1'b0, hung: 1'b0};
    exp_strb = wr ? st : '0;
    @(negedge PCLK);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = a;
    bus.cmd_wdata = wd;
    bus.cmd_strb  = st;
    cyc = 0;
    while (!bus.cmd_ready && cyc < 50) begin @(negedge PCLK); cyc++; end
    if (!bus.cmd_ready) begin r.hung = 1'b1; bus.cmd_valid = 1'b0; return; end
    @(posedge PCLK); #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = AW'($urandom);
    bus.cmd_wdata = $urandom;
    bus.cmd_strb  = SW'($urandom);
    do begin
      @(negedge PCLK);
      r.lat++;
      if (bus.PSEL) begin
        if (bus.PENABLE) r.n_access++; else r.n_setup++;
        if (bus.PADDR !== a || bus.PWRITE !== wr || bus.PSTRB !== exp_strb ||
            (wr && bus.PWDATA !== wd)) r.bus_bad = 1'b1;
      end
    end while (!bus.rsp_valid && r.lat < 60);
    if (!bus.rsp_valid) begin r.hung = 1'b1; return; end
    r.rd  = bus.rsp_rdata;
    r.err = bus.rsp_err;
    r.to  = bus.rsp_timeout;
    for (int h = 0; h < hold; h++) begin
      @(negedge PCLK);
      if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== r.rd || bus.rsp_err !== r.err ||
          bus.rsp_timeout !== r.to || bus.cmd_ready !== 1'b0) r.hold_bad = 1'b1;
    end
    bus.rsp_ready = 1'b1;
    @(posedge PCLK); #1;
    bus.rsp_ready = 1'b0;
    if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1) r.post_bad = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge PCLK);
    vec++; if (bus.cmd_ready !== 1'b1) begin miss++; $display("FAIL rst_cmd_ready: got %b expected 1", bus.cmd_ready); end
    vec++; if ({bus.PSEL, bus.PENABLE, bus.rsp_valid} !== 3'b000) begin miss++; $display("FAIL rst_ctrl: got %b expected 000", {bus.PSEL, bus.PENABLE, bus.rsp_valid}); end
    vec++; if (bus.PADDR !== '0 || bus.PSTRB !== '0 || bus.rsp_err !== 1'b0) begin miss++; $display("FAIL rst_regs: paddr %0h pstrb %0h err %b expected 0", bus.PADDR, bus.PSTRB, bus.rsp_err); end
    PRESET = 1'b0;
  endtask

  task automatic test_write_read();
    res_t r;
    slv_wait = 0; slv_err = 1'b0;
    run_cmd(1'b1, 8'h05, 32'hA5A5_1234, 4'hF, 0, r);
    ref_mem[8'h05] = merge(ref_mem[8'h05], 32'hA5A5_1234, 4'hF);
    vec++; if (r.hung) begin miss++; $display("FAIL wr_hung: got 1 expected 0"); end
    vec++; if (r.lat !== 3) begin miss++; $display("FAIL wr_latency: got %0d expected 3", r.lat); end
    vec++; if (r.n_setup !== 1 || r.n_access !== 1) begin miss++; $display("FAIL wr_phases: setup %0d access %0d expected 1 1", r.n_setup, r.n_access); end
    vec++; if (r.err !== 1'b0 || r.to !== 1'b0 || r.rd !== '0) begin miss++; $display("FAIL wr_rsp: err %b to %b rd %0h expected 0 0 0", r.err, r.to, r.rd); end
    vec++; if (r.bus_bad || r.post_bad) begin miss++; $display("FAIL wr_bus: bus_bad %b post_bad %b expected 0 0", r.bus_bad, r.post_bad); end
    run_cmd(1'b0, 8'h05, 32'h0, 4'hF, 0, r);
    vec++; if (r.lat !== 4) begin miss++; $display("FAIL rd_latency: got %0d expected 4", r.lat); end
    vec++; if (r.rd !== ref_mem[8'h05]) begin miss++; $display("FAIL rd_data: got %0h expected %0h", r.rd, ref_mem[8'h05]); end
    vec++; if (r.bus_bad || r.err !== 1'b0) begin miss++; $display("FAIL rd_bus: bus_bad %b err %b expected 0 0", r.bus_bad, r.err); end
  endtask

  task automatic test_strobes();
    res_t r;
    run_cmd(1'b1, 8'h10, 32'hFFFF_FFFF, 4'hF, 0, r);
    ref_mem[8'h10] = merge(ref_mem[8'h10], 32'hFFFF_FFFF, 4'hF);
    run_cmd(1'b1, 8'h10, 32'h0000_0000, 4'h5, 0, r);
    ref_mem[8'h10] = merge(ref_mem[8'h10], 32'h0000_0000, 4'h5);
    run_cmd(1'b0, 8'h10, 32'h0, 4'hF, 0, r);
    vec++; if (r.rd !== 32'hFF00_FF00) begin miss++; $display("FAIL strb_data: got %0h expected ff00ff00", r.rd); end
    vec++; if (r.rd !== ref_mem[8'h10]) begin miss++; $display("FAIL strb_model: got %0h expected %0h", r.rd, ref_mem[8'h10]); end
    vec++; if (r.bus_bad) begin miss++; $display("FAIL strb_rd_pstrb: got bus_bad 1 expected 0"); end
  endtask

  task automatic test_wait_err();
    res_t r;
    slv_wait = 3; slv_err = 1'b1;
    run_cmd(1'b1, 8'h20, 32'h1357_9BDF, 4'hF, 0, r);
    vec++; if (r.n_access !== 4) begin miss++; $display("FAIL wait_access: got %0d expected 4", r.n_access); end
    vec++; if (r.lat !== 6) begin miss++; $display("FAIL wait_latency: got %0d expected 6", r.lat); end
    vec++; if (r.err !== 1'b1 || r.to !== 1'b0) begin miss++; $display("FAIL wait_err: err %b to %b expected 1 0", r.err, r.to); end
    vec++; if (r.bus_bad) begin miss++; $display("FAIL wait_stable: got bus_bad 1 expected 0"); end
    slv_wait = 0; slv_err = 1'b0;
  endtask

  task automatic test_timeout();
    res_t r;
    slv_wait = 1000;
    run_cmd(1'b0, 8'h05, 32'h0, 4'hF, 0, r);
    vec++; if (r.n_access !== TO) begin miss++; $display("FAIL to_access: got %0d expected %0d", r.n_access, TO); end
    vec++; if (r.lat !== TO + 2) begin miss++; $display("FAIL to_latency: got %0d expected %0d", r.lat, TO + 2); end
    vec++; if (r.err !== 1'b1 || r.to !== 1'b1 || r.rd !== '0) begin miss++; $display("FAIL to_rsp: err %b to %b rd %0h expected 1 1 0", r.err, r.to, r.rd); end
    slv_wait = 0;
  endtask

  task automatic test_hold();
    res_t r;
    run_cmd(1'b0, 8'h05, 32'h0, 4'hF, 5, r);
    vec++; if (r.hold_bad) begin miss++; $display("FAIL hold_stable: got hold_bad 1 expected 0"); end
    vec++; if (r.rd !== ref_mem[8'h05]) begin miss++; $display("FAIL hold_data: got %0h expected %0h", r.rd, ref_mem[8'h05]); end
    vec++; if (r.post_bad) begin miss++; $display("FAIL hold_release: got post_bad 1 expected 0"); end
  endtask

  task automatic test_back_to_back();
    int acc [$];
    int cyc;
    for (int pass = 0; pass < 2; pass++) begin
      acc.delete();
      @(negedge PCLK);
      bus.rsp_ready = 1'b1;
      bus.cmd_valid = 1'b1;
      bus.cmd_write = (pass == 0);
      bus.cmd_addr  = 8'h30;
      bus.cmd_wdata = 32'hC0DE_0030;
      bus.cmd_strb  = 4'hF;
      for (int i = 0; i < 10; i++) begin
        if (bus.cmd_ready) acc.push_back(i);
        @(negedge PCLK);
      end
      bus.cmd_valid = 1'b0;
      cyc = 0;
      while ((!bus.cmd_ready || bus.rsp_valid) && cyc < 40) begin @(negedge PCLK); cyc++; end
      bus.rsp_ready = 1'b0;
      if (pass == 0) ref_mem[8'h30] = merge(ref_mem[8'h30], 32'hC0DE_0030, 4'hF);
      vec++;
      if (acc.size() < 2 || (acc[1] - acc[0]) != ((pass == 0) ? 4 : 5)) begin
        miss++;
        $display("FAIL b2b_spacing_%s: got %0d accepts, gap %0d expected gap %0d", (pass == 0) ? "wr" : "rd",
                 acc.size(), (acc.size() < 2) ? -1 : acc[1] - acc[0], (pass == 0) ? 4 : 5);
      end
    end
  endtask

  task automatic test_reset_mid();
    res_t r;
    int cyc;
    slv_wait = 1000;
    @(negedge PCLK);
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = 8'h05; bus.cmd_strb = 4'hF;
    @(posedge PCLK); #1;
    bus.cmd_valid = 1'b0;
    cyc = 0;
    do begin @(negedge PCLK); cyc++; end while (!bus.PENABLE && cyc < 20);
    vec++; if (bus.PENABLE !== 1'b1) begin miss++; $display("FAIL rstmid_reach_access: got %b expected 1", bus.PENABLE); end
    #1 PRESET = 1'b1;
    #1;
    vec++; if ({bus.PSEL, bus.PENABLE, bus.rsp_valid} !== 3'b000) begin miss++; $display("FAIL rstmid_drop: got %b expected 000", {bus.PSEL, bus.PENABLE, bus.rsp_valid}); end
    @(negedge PCLK);
    PRESET = 1'b0;
    slv_wait = 0;
    @(negedge PCLK);
    vec++; if (bus.cmd_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin miss++; $display("FAIL rstmid_idle: ready %b valid %b expected 1 0", bus.cmd_ready, bus.rsp_valid); end
    run_cmd(1'b0, 8'h05, 32'h0, 4'hF, 0, r);
    vec++; if (r.hung || r.rd !== ref_mem[8'h05] || r.err !== 1'b0) begin miss++; $display("FAIL rstmid_read: rd %0h err %b expected %0h 0", r.rd, r.err, ref_mem[8'h05]); end
  endtask

  task automatic test_random();
    res_t r;
    bit wr;
    logic [AW-1:0] a;
    logic [DW-1:0] wd, exp_rd;
    logic [SW-1:0] st;
    int hold;
    for (int n = 0; n < 40; n++) begin
      wr = 1'($urandom);
      a  = AW'($urandom_range(0, 15));
      wd = $urandom;
      st = SW'($urandom);
      hold     = $urandom_range(0, 2);
      slv_wait = $urandom_range(0, 3);
      slv_err  = ($urandom_range(0, 7) == 0);
      exp_rd   = wr ? '0 : ref_mem[a];
      run_cmd(wr, a, wd, st, hold, r);
      if (wr && !slv_err) ref_mem[a] = merge(ref_mem[a], wd, st);
      vec++;
      if (r.hung || r.rd !== exp_rd || r.err !== slv_err || r.to !== 1'b0) begin
        miss++;
        $display("FAIL rnd_rsp[%0d]: wr %b addr %0h rd %0h err %b to %b expected rd %0h err %b to 0", n, wr, a, r.rd, r.err, r.to, exp_rd, slv_err);
      end
      vec++;
      if (r.lat !== int'((wr ? 3 : 4) + slv_wait) || r.n_access !== int'(slv_wait + 1)) begin
        miss++;
        $display("FAIL rnd_timing[%0d]: lat %0d access %0d expected %0d %0d", n, r.lat, r.n_access, (wr ? 3 : 4) + slv_wait, slv_wait + 1);
      end
      vec++;
      if (r.bus_bad || r.hold_bad || r.post_bad) begin
        miss++;
        $display("FAIL rnd_bus[%0d]: bus %b hold %b post %b expected 0 0 0", n, r.bus_bad, r.hold_bad, r.post_bad);
      end
    end
    slv_wait = 0; slv_err = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.cmd_strb  = '0;
    bus.rsp_ready = 1'b0;
    bus.PRDATA    = '0;
    test_reset();
    test_write_read();
    test_strobes();
    test_wait_err();
    test_timeout();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
